ensemble_majority_voter: RTL

Downstream of the three-classifier ensemble wrapper. Consumes the three per-classifier AXI-Stream result streams, aligns them sample-by-sample with small per-input FIFOs, and emits one majority-voted class label per sample on a single AXI-Stream master. Also keeps running vote statistics for software readout.

---
 rtl/ensemble_majority_voter.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/ensemble_majority_voter.sv
// ensemble_majority_voter
//   Aligns three per-classifier AXI-Stream result streams through small
//   per-input FIFOs and emits one majority-voted class label per sample.
//   Also keeps running counts of delivered votes and no-majority votes.
//
// Ports
//   clk, rst                    rising-edge clock, async active-high reset
//   s_axis_*_0/1/2              classifier result streams (slave side);
//                               label = tdata[CLASS_WIDTH-1:0], tkeep ignored
//   m_axis_*                    voted result stream (master side);
//                               tdata = {.., last_mismatch[18], unanimous[17],
//                                        no_majority[16], .., label}
//   vote_count                  results accepted downstream (wraps)
//   no_majority_count           accepted no-majority results (saturates)
module ensemble_majority_voter #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned KEEP_WIDTH  = 4,
  parameter int unsigned CLASS_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned TIE_SEL     = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata_0,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep_0,
  input  logic                  s_axis_tvalid_0,
  output logic                  s_axis_tready_0,
  input  logic                  s_axis_tlast_0,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata_1,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep_1,
  input  logic                  s_axis_tvalid_1,
  output logic                  s_axis_tready_1,
  input  logic                  s_axis_tlast_1,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata_2,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep_2,
  input  logic                  s_axis_tvalid_2,
  output logic                  s_axis_tready_2,
  input  logic                  s_axis_tlast_2,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [31:0]           vote_count,
  output logic [15:0]           no_majority_count
);

  localparam int unsigned PW      = $clog2(FIFO_DEPTH);
  localparam logic [1:0]  TIE_IDX = 2'(TIE_SEL);

  // FIFO entry: {tlast, label}
  logic [CLASS_WIDTH:0]   w_din    [3];
  logic [CLASS_WIDTH:0]   w_head   [3];
  logic [CLASS_WIDTH-1:0] w_lbl    [3];
  logic [CLASS_WIDTH:0]   r_mem    [3][FIFO_DEPTH];
  logic [PW:0]            r_wr_ptr [3];
  logic [PW:0]            r_rd_ptr [3];
  logic [2:0]             w_valid_in;
  logic [2:0]             w_full;
  logic [2:0]             w_empty;
  logic [2:0]             w_push;
  logic [2:0]             w_last;
  logic                   w_fire;
  logic [CLASS_WIDTH-1:0] w_vote;
  logic                   w_no_maj;
  logic                   w_unan;
  logic                   w_last_mis;
  logic [DATA_WIDTH-1:0]  w_res;

  logic                   r_tvalid;
  logic [DATA_WIDTH-1:0]  r_tdata;
  logic                   r_tlast;
  logic [31:0]            r_vote_count;
  logic [15:0]            r_nm_count;
  logic                   w_unused;

  assign w_din[0]   = {s_axis_tlast_0, s_axis_tdata_0[CLASS_WIDTH-1:0]};
  assign w_din[1]   = {s_axis_tlast_1, s_axis_tdata_1[CLASS_WIDTH-1:0]};
  assign w_din[2]   = {s_axis_tlast_2, s_axis_tdata_2[CLASS_WIDTH-1:0]};
  assign w_valid_in = {s_axis_tvalid_2, s_axis_tvalid_1, s_axis_tvalid_0};

  assign w_unused = ^{s_axis_tkeep_0, s_axis_tkeep_1, s_axis_tkeep_2,
                      s_axis_tdata_0[DATA_WIDTH-1:CLASS_WIDTH],
                      s_axis_tdata_1[DATA_WIDTH-1:CLASS_WIDTH],
                      s_axis_tdata_2[DATA_WIDTH-1:CLASS_WIDTH]};

  // Flags come straight from the registered pointers, so a pop on a full
  // FIFO only reopens tready on the following cycle.
  always_comb begin
    for (int unsigned k = 0; k < 3; k++) begin
      w_full[k]  = (r_wr_ptr[k][PW] != r_rd_ptr[k][PW]) &&
                   (r_wr_ptr[k][PW-1:0] == r_rd_ptr[k][PW-1:0]);
      w_empty[k] = (r_wr_ptr[k] == r_rd_ptr[k]);
      w_push[k]  = w_valid_in[k] && !w_full[k];
      w_head[k]  = r_mem[k][r_rd_ptr[k][PW-1:0]];
      w_lbl[k]   = w_head[k][CLASS_WIDTH-1:0];
      w_last[k]  = w_head[k][CLASS_WIDTH];
    end
  end

  assign s_axis_tready_0 = ~w_full[0];
  assign s_axis_tready_1 = ~w_full[1];
  assign s_axis_tready_2 = ~w_full[2];

  assign w_fire = ~|w_empty && (!r_tvalid || m_axis_tready);

  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < 3; k++) begin
      if (w_push[k]) r_mem[k][r_wr_ptr[k][PW-1:0]] <= w_din[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < 3; k++) begin
        r_wr_ptr[k] <= '0;
        r_rd_ptr[k] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < 3; k++) begin
        if (w_push[k]) r_wr_ptr[k] <= r_wr_ptr[k] + (PW+1)'(1);
        if (w_fire)    r_rd_ptr[k] <= r_rd_ptr[k] + (PW+1)'(1);
      end
    end
  end

  always_comb begin
    w_no_maj = 1'b0;
    if (w_lbl[0] == w_lbl[1] || w_lbl[0] == w_lbl[2]) begin
      w_vote = w_lbl[0];
    end else if (w_lbl[1] == w_lbl[2]) begin
      w_vote = w_lbl[1];
    end else begin
      w_vote   = w_lbl[TIE_IDX];
      w_no_maj = 1'b1;
    end
    w_unan     = (w_lbl[0] == w_lbl[1]) && (w_lbl[1] == w_lbl[2]);
    w_last_mis = !((w_last[0] == w_last[1]) && (w_last[1] == w_last[2]));
    w_res                  = '0;
    w_res[CLASS_WIDTH-1:0] = w_vote;
    w_res[16]              = w_no_maj;
    w_res[17]              = w_unan;
    w_res[18]              = w_last_mis;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tvalid     <= 1'b0;
      r_tdata      <= '0;
      r_tlast      <= 1'b0;
      r_vote_count <= '0;
      r_nm_count   <= '0;
    end else begin
      if (w_fire) begin
        r_tvalid <= 1'b1;
        r_tdata  <= w_res;
        r_tlast  <= |w_last;
      end else if (m_axis_tready) begin
        r_tvalid <= 1'b0;
      end
      if (r_tvalid && m_axis_tready) begin
        r_vote_count <= r_vote_count + 32'd1;
        if (r_tdata[16] && (r_nm_count != '1)) r_nm_count <= r_nm_count + 16'd1;
      end
    end
  end

  assign m_axis_tvalid     = r_tvalid;
  assign m_axis_tdata      = r_tdata;
  assign m_axis_tlast      = r_tlast;
  assign m_axis_tkeep      = {KEEP_WIDTH{r_tvalid}};
  assign vote_count        = r_vote_count;
  assign no_majority_count = r_nm_count;

endmodule
